instr_decoder_pipe: RTL and testbench
=====================================

Name: instr_decoder_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle instruction decoder.
- Accepts packed instructions {op, rd, rs, imm} over a valid/ready handshake and registers decoded control strobes and fields.
- Adds a multi-cycle load wait state, illegal-opcode flagging, R0 write suppression and a retired-instruction counter.
- Sits between the fetch stage and the register-file/memory execute stage.

Parameters:
- OP_W, 3, opcode width; codes 0..5 defined, codes 6 and above illegal.
- REG_W, 3, width of the rd and rs register index fields.
- IMM_W, 8, immediate field width.
- LOAD_LAT, 2, cycles from LOAD acceptance to out_valid; legal range 1 and up.
- CNT_W, 8, width of the retired counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_instr  in  OP_W+2*REG_W+IMM_W  packed {op, rd, rs, imm}, op in the MSBs.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  decoder can accept an instruction this cycle.
- out_valid  out  1  decoded instruction valid.
- out_ready  in  1  downstream consumes the decoded instruction.
- out_op  out  OP_W  registered opcode.
- out_rd  out  REG_W  registered destination index.
- out_rs  out  REG_W  registered source index.
- out_imm  out  IMM_W  registered immediate.
- wen_reg  out  1  register-file write enable.
- ren_mem  out  1  memory read enable.
- wen_mem  out  1  memory write enable.
- illegal  out  1  opcode undefined.
- busy  out  1  state is MEM_WAIT.
- retired  out  CNT_W  count of handed-off instructions.

Behaviour:
- Clock and reset: single clock clk; reset rst is asynchronous and active-low.
- Reset (rst=0) clears immediately, independent of clk:
  - All outputs go to 0 except in_ready.
  - The state goes to RUN and wait_cnt goes to 0.
  - in_ready is 0 while rst=0 and follows the run equation after release.
- Reset asserted mid-MEM_WAIT or with out_valid=1 discards the pending instruction; retired is not incremented.
- Handshake:
  - in_ready = (state==RUN) && (!out_valid || out_ready).
  - An instruction is accepted when in_valid && in_ready at a rising edge.
  - Handoff occurs when out_valid && out_ready at a rising edge.
- Output stability: while out_valid=1 && out_ready=0, all out_* fields and strobes hold stable.
- Accept and handoff in the same edge is allowed and gives full throughput: one instruction per cycle, no bubble.
- Decode table (strobes are registered at acceptance):
  - 0 NOP: no strobes.
  - 1 ADD and 2 SUB: wen_reg.
  - 3 LOAD: ren_mem and wen_reg.
  - 4 STORE: wen_mem.
  - 5 ADDI: wen_reg.
  - 6 and above: illegal=1 and all enables 0.
- R0 rule: wen_reg is forced to 0 when rd==0, for every opcode.
- Strobe gating: wen_reg, ren_mem, wen_mem and illegal are 0 whenever out_valid=0.
- Non-LOAD latency: out_valid rises at the acceptance edge, one cycle after the in_valid sample.
- LOAD latency:
  - At the acceptance edge, fields are captured, state goes to MEM_WAIT, wait_cnt is loaded with LOAD_LAT-1, and out_valid stays 0.
  - If LOAD_LAT==1, a LOAD behaves like a non-LOAD: state stays RUN and out_valid rises at acceptance.
- MEM_WAIT:
  - busy=1 and in_ready=0.
  - wait_cnt decrements each edge.
  - On the edge where wait_cnt==1, out_valid goes to 1 and state returns to RUN.
  - out_valid therefore rises LOAD_LAT edges after acceptance.
- An illegal opcode is still passed downstream with out_valid=1 so it can trap; it counts as retired.
- retired increments by 1 on each handoff and wraps from 2^CNT_W-1 to 0.

Test Plan:
- Reset: hold rst=0 for 3 cycles with in_valid=1 -> all outputs 0 and in_ready=0; after release in_ready=1.
- Back-to-back stream:
  - Stimulus: in_valid=1, out_ready=1, ops ADD rd=2, SUB rd=3, STORE, ADDI rd=1.
  - Required: one out_valid per cycle, strobes 100, 100, 001, 100 as {wen_reg, ren_mem, wen_mem}, retired=4.
- LOAD with LOAD_LAT=2: LOAD rd=5 accepted -> busy=1 and in_ready=0 for 1 cycle; out_valid rises 2 edges after acceptance with wen_reg=1 and ren_mem=1.
- Backpressure: out_ready=0 for 4 cycles holding ADD rd=4 imm=0x5A -> outputs stable, in_ready=0; release gives one handoff and retired increments once.
- Boundaries:
  - ADD rd=0 -> wen_reg=0.
  - op=7 -> illegal=1 with enables 0.
  - 256 handoffs with CNT_W=8 -> retired wraps to 0.
- Mid-operation reset: assert rst during MEM_WAIT -> out_valid=0, busy=0, retired unchanged at 0; the next instruction decodes normally.

Source files
------------

// File: rtl/instr_decoder_pipe.sv
// Pipelined instruction decoder: registers op/rd/rs/imm plus control strobes on a valid/ready handshake.
// Non-LOAD results appear one edge after acceptance and LOAD results LOAD_LAT edges after acceptance; a stalled output holds and blocks intake.
module instr_decoder_pipe #(
  parameter int OP_W     = 3,
  parameter int REG_W    = 3,
  parameter int IMM_W    = 8,
  parameter int LOAD_LAT = 2,
  parameter int CNT_W    = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [OP_W+2*REG_W+IMM_W-1:0] in_instr,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OP_W-1:0]               out_op,
  output logic [REG_W-1:0]              out_rd,
  output logic [REG_W-1:0]              out_rs,
  output logic [IMM_W-1:0]              out_imm,
  output logic                          wen_reg,
  output logic                          ren_mem,
  output logic                          wen_mem,
  output logic                          illegal,
  output logic                          busy,
  output logic [CNT_W-1:0]              retired
);

  localparam int WC_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

  localparam logic [OP_W-1:0] OP_NOP   = OP_W'(0);
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(1);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_STORE = OP_W'(4);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(5);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_e;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs;
    logic [IMM_W-1:0] imm;
  } instr_t;

  typedef struct packed {
    logic wen_reg;
    logic ren_mem;
    logic wen_mem;
    logic illegal;
  } ctl_t;

  state_e           state_q, state_d;
  logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic             out_valid_q, out_valid_d;
  instr_t           fields_q, fields_d;
  ctl_t             ctl_q, ctl_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  instr_t in_fields;
  ctl_t   dec;
  logic   accept;
  logic   handoff;

  assign in_fields = instr_t'(in_instr);
  assign accept    = in_valid && in_ready;
  assign handoff   = out_valid_q && out_ready;

  always_comb begin
    dec = '0;
    case (in_fields.op)
      OP_NOP:                   ;
      OP_ADD, OP_SUB, OP_ADDI:  dec.wen_reg = 1'b1;
      OP_LOAD: begin
        dec.wen_reg = 1'b1;
        dec.ren_mem = 1'b1;
      end
      OP_STORE:                 dec.wen_mem = 1'b1;
      default:                  dec.illegal = 1'b1;
    endcase
    // R0 is hardwired, so no opcode may write it.
    if (in_fields.rd == '0) dec.wen_reg = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      fields_q    <= '0;
      ctl_q       <= '0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      out_valid_q <= out_valid_d;
      fields_q    <= fields_d;
      ctl_q       <= ctl_d;
      retired_q   <= retired_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    out_valid_d = out_valid_q;
    fields_d    = fields_q;
    ctl_d       = ctl_q;
    retired_d   = retired_q;

    if (handoff) begin
      out_valid_d = 1'b0;
      retired_d   = retired_q + CNT_W'(1);
    end

    case (state_q)
      RUN: begin
        if (accept) begin
          fields_d = in_fields;
          ctl_d    = dec;
          if ((in_fields.op == OP_LOAD) && (LOAD_LAT > 1)) begin
            state_d     = MEM_WAIT;
            wait_cnt_d  = WC_W'(LOAD_LAT - 1);
            out_valid_d = 1'b0;
          end else begin
            out_valid_d = 1'b1;
          end
        end
      end
      MEM_WAIT: begin
        wait_cnt_d = wait_cnt_q - WC_W'(1);
        if (wait_cnt_q == WC_W'(1)) begin
          out_valid_d = 1'b1;
          state_d     = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    in_ready  = rst && (state_q == RUN) && (!out_valid_q || out_ready);
    busy      = (state_q == MEM_WAIT);
    out_valid = out_valid_q;
    out_op    = fields_q.op;
    out_rd    = fields_q.rd;
    out_rs    = fields_q.rs;
    out_imm   = fields_q.imm;
    wen_reg   = ctl_q.wen_reg && out_valid_q;
    ren_mem   = ctl_q.ren_mem && out_valid_q;
    wen_mem   = ctl_q.wen_mem && out_valid_q;
    illegal   = ctl_q.illegal && out_valid_q;
    retired   = retired_q;
  end

endmodule

// File: tb/tb_instr_decoder_pipe.sv
// Bench for instr_decoder_pipe: directed scenarios followed by a randomized run against a transaction-level model.
module tb_instr_decoder_pipe;

  localparam int OP_W = 3, REG_W = 3, IMM_W = 8, LOAD_LAT = 2, CNT_W = 8;
  localparam int IW = OP_W + 2 * REG_W + IMM_W;

  logic             clk = 1'b0;
  logic             rst;
  logic [IW-1:0]    in_instr;
  logic             in_valid;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [OP_W-1:0]  out_op;
  logic [REG_W-1:0] out_rd;
  logic [REG_W-1:0] out_rs;
  logic [IMM_W-1:0] out_imm;
  logic             wen_reg, ren_mem, wen_mem, illegal, busy;
  logic [CNT_W-1:0] retired;

  int n_cmp = 0;
  int n_err = 0;
  int exp_ret = 0;

  instr_decoder_pipe #(.OP_W(OP_W), .REG_W(REG_W), .IMM_W(IMM_W), .LOAD_LAT(LOAD_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_instr(in_instr), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_rd(out_rd), .out_rs(out_rs),
    .out_imm(out_imm), .wen_reg(wen_reg), .ren_mem(ren_mem), .wen_mem(wen_mem), .illegal(illegal),
    .busy(busy), .retired(retired)
  );

  always #5 clk = ~clk;

  function automatic logic [IW-1:0] mk(int op, int rd, int rs, int imm);
    logic [31:0] o, d, s, m;
    o = op; d = rd; s = rs; m = imm;
    return {o[OP_W-1:0], d[REG_W-1:0], s[REG_W-1:0], m[IMM_W-1:0]};
  endfunction

  // Expected {wen_reg, ren_mem, wen_mem, illegal} straight from the opcode table.
  function automatic logic [3:0] exp_strb(int op, int rd);
    logic wr, rm, wm, il;
    wr = (op == 1 || op == 2 || op == 3 || op == 5) && (rd != 0);
    rm = (op == 3);
    wm = (op == 4);
    il = (op >= 6);
    return {wr, rm, wm, il};
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_instr = '0;
    #2 rst = 1'b0;
    in_valid = 1'b1; in_instr = mk(1, 2, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({out_valid, wen_reg, ren_mem, wen_mem, illegal, busy} !== 6'b0) begin
      n_err++; $display("FAIL reset_ctl: got %b want 000000", {out_valid, wen_reg, ren_mem, wen_mem, illegal, busy});
    end
    n_cmp++;
    if ({out_op, out_rd, out_rs, out_imm, retired} !== '0) begin
      n_err++; $display("FAIL reset_fields: got op=%0d rd=%0d rs=%0d imm=%0h ret=%0d want all 0", out_op, out_rd, out_rs, out_imm, retired);
    end
    n_cmp++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_back_to_back();
    logic [IW-1:0] seq [4];
    logic [2:0]    exp_s [4];
    seq[0] = mk(1, 2, 1, 8'h11); exp_s[0] = 3'b100;
    seq[1] = mk(2, 3, 2, 8'h22); exp_s[1] = 3'b100;
    seq[2] = mk(4, 1, 3, 8'h33); exp_s[2] = 3'b001;
    seq[3] = mk(5, 1, 4, 8'h44); exp_s[3] = 3'b100;
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_instr = seq[0];
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || {wen_reg, ren_mem, wen_mem} !== exp_s[i-1] || in_ready !== 1'b1
          || {out_op, out_rd, out_rs, out_imm} !== seq[i-1]) begin
        n_err++;
        $display("FAIL b2b_%0d: got vld=%b strb=%b rdy=%b instr=%h want vld=1 strb=%b rdy=1 instr=%h",
                 i - 1, out_valid, {wen_reg, ren_mem, wen_mem}, in_ready, {out_op, out_rd, out_rs, out_imm}, exp_s[i-1], seq[i-1]);
      end
      if (i < 4) in_instr = seq[i];
      else in_valid = 1'b0;
    end
    @(negedge clk);
    exp_ret += 4;
    n_cmp++;
    if (out_valid !== 1'b0 || retired !== CNT_W'(exp_ret)) begin
      n_err++; $display("FAIL b2b_retired: got vld=%b ret=%0d want vld=0 ret=%0d", out_valid, retired, exp_ret);
    end
  endtask

  task automatic test_load();
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_instr = mk(3, 5, 1, 8'h33);
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL load_wait: got busy=%b rdy=%b vld=%b want 1 0 0", busy, in_ready, out_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || {wen_reg, ren_mem, wen_mem, illegal} !== 4'b1100 || busy !== 1'b0 || out_rd !== 3'd5) begin
      n_err++; $display("FAIL load_done: got vld=%b strb=%b busy=%b rd=%0d want 1 1100 0 5",
                        out_valid, {wen_reg, ren_mem, wen_mem, illegal}, busy, out_rd);
    end
    @(negedge clk);
    exp_ret += 1;
    n_cmp++;
    if (out_valid !== 1'b0 || retired !== CNT_W'(exp_ret)) begin
      n_err++; $display("FAIL load_retired: got vld=%b ret=%0d want 0 %0d", out_valid, retired, exp_ret);
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_instr = mk(1, 4, 2, 8'h5A);
    @(negedge clk);
    in_instr = mk(2, 6, 6, 8'hC3);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || out_op !== 3'd1 || out_rd !== 3'd4 || out_rs !== 3'd2 || out_imm !== 8'h5A
          || wen_reg !== 1'b1 || in_ready !== 1'b0 || retired !== CNT_W'(exp_ret)) begin
        n_err++;
        $display("FAIL stall_%0d: got vld=%b op=%0d rd=%0d rs=%0d imm=%h wen=%b rdy=%b ret=%0d want 1 1 4 2 5a 1 0 %0d",
                 k, out_valid, out_op, out_rd, out_rs, out_imm, wen_reg, in_ready, retired, exp_ret);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    exp_ret += 1;
    n_cmp++;
    if (out_valid !== 1'b0 || retired !== CNT_W'(exp_ret)) begin
      n_err++; $display("FAIL stall_release: got vld=%b ret=%0d want 0 %0d", out_valid, retired, exp_ret);
    end
  endtask

  task automatic test_r0_and_illegal();
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_instr = mk(1, 0, 3, 8'h01);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || {wen_reg, ren_mem, wen_mem, illegal} !== 4'b0000) begin
      n_err++; $display("FAIL r0_add: got vld=%b strb=%b want 1 0000", out_valid, {wen_reg, ren_mem, wen_mem, illegal});
    end
    in_instr = mk(7, 3, 1, 8'hFF);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || {wen_reg, ren_mem, wen_mem, illegal} !== 4'b0001 || out_op !== 3'd7) begin
      n_err++; $display("FAIL illegal_op7: got vld=%b strb=%b op=%0d want 1 0001 7", out_valid, {wen_reg, ren_mem, wen_mem, illegal}, out_op);
    end
    in_instr = mk(6, 2, 1, 8'h10);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || {wen_reg, ren_mem, wen_mem, illegal} !== 4'b0001) begin
      n_err++; $display("FAIL illegal_op6: got vld=%b strb=%b want 1 0001", out_valid, {wen_reg, ren_mem, wen_mem, illegal});
    end
    in_valid = 1'b0;
    @(negedge clk);
    exp_ret += 3;
    n_cmp++;
    if (retired !== CNT_W'(exp_ret)) begin
      n_err++; $display("FAIL illegal_retired: got %0d want %0d", retired, exp_ret);
    end
  endtask

  task automatic test_wrap();
    int n;
    n = 256 - (exp_ret % 256);
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_instr = mk(0, 0, 0, 0);
    for (int j = 1; j <= n; j++) begin
      @(negedge clk);
      if (j == n) begin
        in_valid = 1'b0;
        n_cmp++;
        if (retired !== 8'hFF) begin n_err++; $display("FAIL wrap_pre: got %0d want 255", retired); end
      end
    end
    @(negedge clk);
    exp_ret = 0;
    n_cmp++;
    if (retired !== 8'h00 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL wrap_zero: got ret=%0d vld=%b want 0 0", retired, out_valid);
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_instr = mk(3, 4, 2, 8'h77);
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL midrst_pre_busy: got %b want 1", busy); end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || retired !== 8'd0 || in_ready !== 1'b0) begin
      n_err++; $display("FAIL midrst_clear: got vld=%b busy=%b ret=%0d rdy=%b want 0 0 0 0", out_valid, busy, retired, in_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || retired !== 8'd0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL midrst_after: got vld=%b ret=%0d rdy=%b want 0 0 1", out_valid, retired, in_ready);
    end
    in_valid = 1'b1; in_instr = mk(5, 7, 3, 8'hA5);
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || {wen_reg, ren_mem, wen_mem, illegal} !== 4'b1000 || out_rd !== 3'd7 || out_imm !== 8'hA5) begin
      n_err++; $display("FAIL midrst_next: got vld=%b strb=%b rd=%0d imm=%h want 1 1000 7 a5",
                        out_valid, {wen_reg, ren_mem, wen_mem, illegal}, out_rd, out_imm);
    end
    @(negedge clk);
    exp_ret = 1;
  endtask

  // At most one instruction is in flight; it becomes visible after its latency and leaves on handoff.
  task automatic test_random();
    bit            has_item = 0;
    int            remaining = 0;
    logic [IW-1:0] item = '0;
    int            m_ret = exp_ret;
    bit            exp_vld, exp_busy, exp_rdy, hand, acc;
    logic [3:0]    es;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      in_instr  = IW'($urandom);
      #1;
      exp_vld  = has_item && (remaining == 0);
      exp_busy = has_item && (remaining > 0);
      exp_rdy  = !exp_busy && (!exp_vld || out_ready);
      es = exp_vld ? exp_strb(int'(item[IW-1 -: OP_W]), int'(item[IW-OP_W-1 -: REG_W])) : 4'b0;
      n_cmp++;
      if (out_valid !== exp_vld || busy !== exp_busy || in_ready !== exp_rdy || retired !== CNT_W'(m_ret)
          || {wen_reg, ren_mem, wen_mem, illegal} !== es) begin
        n_err++;
        $display("FAIL rand_ctl cyc %0d: got vld=%b busy=%b rdy=%b ret=%0d strb=%b want %b %b %b %0d %b",
                 c, out_valid, busy, in_ready, retired, {wen_reg, ren_mem, wen_mem, illegal},
                 exp_vld, exp_busy, exp_rdy, CNT_W'(m_ret), es);
      end
      if (exp_vld) begin
        n_cmp++;
        if ({out_op, out_rd, out_rs, out_imm} !== item) begin
          n_err++; $display("FAIL rand_fields cyc %0d: got %h want %h", c, {out_op, out_rd, out_rs, out_imm}, item);
        end
      end
      hand = exp_vld && out_ready;
      acc  = in_valid && exp_rdy;
      if (hand) begin has_item = 0; m_ret++; end
      if (acc) begin
        has_item  = 1;
        item      = in_instr;
        remaining = (int'(in_instr[IW-1 -: OP_W]) == 3) ? LOAD_LAT - 1 : 0;
      end else if (has_item && remaining > 0) begin
        remaining--;
      end
    end
    exp_ret = m_ret;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_load();
    test_backpressure();
    test_r0_and_illegal();
    test_wrap();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
